// File: rtl/sfa_pkg.sv
// Shared types and constants for the serial frame arbiter: FSM states,
// header geometry and a one-hot to index helper.
package sfa_pkg;

  localparam int HDR_BITS = 8;
  localparam int PORT_W   = 2;
  localparam int LEN_W    = 6;
  localparam int N_REQ    = 4;

  typedef enum logic [2:0] {IDLE, START, HDR, PAY, STOP} sfa_state_t;

  function automatic logic [PORT_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = PORT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/serial_frame_arbiter_rr.sv
// Combinational round-robin winner selection over four requesters,
// starting the search at ptr and wrapping modulo 4.
module rr_arbiter4
  import sfa_pkg::*;
(
  input  logic [N_REQ-1:0]  req,
  input  logic [PORT_W-1:0] ptr,
  output logic [N_REQ-1:0]  winner,
  output logic              valid
);

  logic [PORT_W-1:0] idx;

  // Walk from the farthest position back to ptr so the nearest requester wins last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + PORT_W'(i);
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_frame_arbiter.sv
// Shares one serial line among four requesters, sending start bit, 8-bit
// header {len, port}, payload and stop bit for each granted frame.
module serial_frame_arbiter #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic [N_REQ-1:0]       bit_in,
  output logic                   sout,
  output logic [N_REQ-1:0]       grant,
  output logic                   take,
  output logic                   busy,
  output logic                   done
);
  import sfa_pkg::*;

  localparam logic [2:0] HDR_LAST = 3'(HDR_BITS - 1);

  sfa_state_t        state, state_nxt;
  logic [2:0]        hdr_cnt, hdr_cnt_nxt;
  logic [LEN_W-1:0]  pay_cnt, pay_cnt_nxt;
  logic [LEN_W-1:0]  len_lat, len_nxt;
  logic [PORT_W-1:0] owner, owner_nxt;
  logic [PORT_W-1:0] ptr, ptr_nxt;
  logic [N_REQ-1:0]  win_oh;
  logic              win_valid;
  logic [PORT_W-1:0] win_idx;
  logic [HDR_BITS-1:0] hdr_word;

  rr_arbiter4 u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (win_oh),
    .valid  (win_valid)
  );

  assign win_idx  = onehot_to_idx(win_oh);
  assign hdr_word = {len_lat, owner};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hdr_cnt <= '0;
      pay_cnt <= '0;
      len_lat <= '0;
      owner   <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      hdr_cnt <= hdr_cnt_nxt;
      pay_cnt <= pay_cnt_nxt;
      len_lat <= len_nxt;
      owner   <= owner_nxt;
      ptr     <= ptr_nxt;
    end
  end

  // Outputs decode only from registered state; bit_in reaches sout in PAY only.
  always_comb begin
    state_nxt   = state;
    hdr_cnt_nxt = hdr_cnt;
    pay_cnt_nxt = pay_cnt;
    len_nxt     = len_lat;
    owner_nxt   = owner;
    ptr_nxt     = ptr;
    sout        = 1'b1;
    grant       = '0;
    take        = 1'b0;
    busy        = (state != IDLE);
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          owner_nxt = win_idx;
          len_nxt   = len[win_idx*LEN_W +: LEN_W];
          ptr_nxt   = win_idx + PORT_W'(1);
          state_nxt = START;
        end
      end
      START: begin
        sout         = 1'b0;
        grant[owner] = 1'b1;
        hdr_cnt_nxt  = '0;
        state_nxt    = HDR;
      end
      HDR: begin
        sout         = hdr_word[HDR_LAST - hdr_cnt];
        grant[owner] = 1'b1;
        hdr_cnt_nxt  = hdr_cnt + 3'd1;
        if (hdr_cnt == HDR_LAST) begin
          if (len_lat != '0) begin
            pay_cnt_nxt = len_lat;
            state_nxt   = PAY;
          end else begin
            state_nxt = STOP;
          end
        end
      end
      PAY: begin
        sout         = bit_in[owner];
        take         = 1'b1;
        grant[owner] = 1'b1;
        pay_cnt_nxt  = pay_cnt - LEN_W'(1);
        if (pay_cnt == LEN_W'(1)) state_nxt = STOP;
      end
      STOP: begin
        done         = 1'b1;
        grant[owner] = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Directed self-checking bench for serial_frame_arbiter: reset, single frame,
// zero length, round robin, fairness and mid-frame reset scenarios.
module tb_serial_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [23:0] len;
  logic [3:0]  bit_in;
  logic        sout;
  logic [3:0]  grant;
  logic        take;
  logic        busy;
  logic        done;

  int checks = 0;
  int fails  = 0;

  serial_frame_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .len    (len),
    .bit_in (bit_in),
    .sout   (sout),
    .grant  (grant),
    .take   (take),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Bounded wait for the STOP cycle; returns at the negedge where done is seen.
  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1; req = 4'b1111; len = '0; bit_in = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (sout !== 1'b1 || grant !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || take !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_hold: sout=%b grant=%b busy=%b done=%b take=%b, required 1 0000 0 0 0",
                 sout, grant, busy, done, take);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || sout !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_first_grant: grant=%b sout=%b busy=%b, required 0001 0 1", grant, sout, busy);
    end
    req = 4'b0000;
    wait_done(seen);
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL reset_frame_done: done not seen, required a done pulse");
    end
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    bit [12:0] exp_sout = 13'b0000011011011;
    bit        pay [3]  = '{1'b1, 1'b0, 1'b1};
    int        k = 0;
    int        takes = 0;
    len = '0; len[6 +: 6] = 6'd3;
    bit_in = 4'b0000; bit_in[1] = pay[0];
    req = 4'b0010;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      checks++;
      if (sout !== exp_sout[13-c]) begin
        fails++;
        $display("[TB] FAIL single_sout c=%0d: sout=%b, required %b", c, sout, exp_sout[13-c]);
      end
      checks++;
      if (grant !== 4'b0010) begin
        fails++;
        $display("[TB] FAIL single_grant c=%0d: grant=%b, required 0010", c, grant);
      end
      checks++;
      if (done !== (c == 13)) begin
        fails++;
        $display("[TB] FAIL single_done c=%0d: done=%b, required %b", c, done, (c == 13));
      end
      if (c == 13) req = 4'b0000;
      if (take === 1'b1) begin
        takes++;
        @(posedge clk);
        #1;
        k++;
        if (k < 3) bit_in[1] = pay[k];
      end
    end
    checks++;
    if (takes != 3) begin
      fails++;
      $display("[TB] FAIL single_take_count: take cycles=%0d, required 3", takes);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000 || sout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL single_idle_gap: busy=%b grant=%b sout=%b, required 0 0000 1", busy, grant, sout);
    end
  endtask

  task automatic test_zero_length();
    bit [9:0] exp_sout = 10'b0000000101;
    len = '0;
    bit_in = 4'b1111;
    req = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (sout !== exp_sout[10-c] || grant !== 4'b0100 || take !== 1'b0 || done !== (c == 10)) begin
        fails++;
        $display("[TB] FAIL zero_len c=%0d: sout=%b grant=%b take=%b done=%b, required %b 0100 0 %b",
                 c, sout, grant, take, done, exp_sout[10-c], (c == 10));
      end
      if (c == 10) req = 4'b0000;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_len_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_round_robin();
    bit         seen;
    logic [3:0] exp_grant;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    len = {6'd1, 6'd1, 6'd1, 6'd1};
    bit_in = 4'b1111;
    req = 4'b1111;
    for (int f = 0; f < 4; f++) begin
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        exp_grant = (c <= 11) ? 4'(1 << f) : 4'b0000;
        checks++;
        if (grant !== exp_grant || busy !== (c <= 11) || done !== (c == 11)) begin
          fails++;
          $display("[TB] FAIL rr_frame%0d c=%0d: grant=%b busy=%b done=%b, required %b %b %b",
                   f, c, grant, busy, done, exp_grant, (c <= 11), (c == 11));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL rr_wrap: grant=%b, required 0001", grant);
    end
    req = 4'b0000;
    wait_done(seen);
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL rr_wrap_done: done not seen, required a done pulse");
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    bit seen;
    len = '0; len[0 +: 6] = 6'd3; len[12 +: 6] = 6'd2;
    bit_in = 4'b0000;
    req = 4'b0001;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (grant !== 4'b0001) begin
          fails++;
          $display("[TB] FAIL fair_first: grant=%b, required 0001", grant);
        end
      end
      if (c == 10) req = 4'b0101;
      if (c == 13 || c == 26) begin
        checks++;
        if (done !== 1'b1) begin
          fails++;
          $display("[TB] FAIL fair_done c=%0d: done=%b, required 1", c, done);
        end
      end
      if (c == 14) begin
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
          fails++;
          $display("[TB] FAIL fair_gap: grant=%b busy=%b, required 0000 0", grant, busy);
        end
      end
      if (c == 15) begin
        checks++;
        if (grant !== 4'b0100) begin
          fails++;
          $display("[TB] FAIL fair_second: grant=%b, required 0100", grant);
        end
      end
      if (c == 26) req = 4'b0001;
      if (c == 28) begin
        checks++;
        if (grant !== 4'b0001) begin
          fails++;
          $display("[TB] FAIL fair_third: grant=%b, required 0001", grant);
        end
      end
    end
    req = 4'b0000;
    wait_done(seen);
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL fair_last_done: done not seen, required a done pulse");
    end
    @(negedge clk);
  endtask

  task automatic test_mid_frame_reset();
    bit seen;
    len = '0; len[0 +: 6] = 6'd5; len[18 +: 6] = 6'd1;
    bit_in = 4'b0000;
    req = 4'b0001;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
    end
    checks++;
    if (take !== 1'b1 || grant !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL mid_rst_pay: take=%b grant=%b, required 1 0001", take, grant);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sout !== 1'b1 || grant !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || take !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_rst_abort: sout=%b grant=%b busy=%b done=%b take=%b, required 1 0000 0 0 0",
               sout, grant, busy, done, take);
    end
    rst = 1'b0;
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL mid_rst_ptr: grant=%b, required 0001", grant);
    end
    req = 4'b0000;
    wait_done(seen);
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL mid_rst_done: done not seen, required a done pulse");
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting serial_frame_arbiter bench");
    test_reset();
    test_single_frame();
    test_zero_length();
    test_round_robin();
    test_fairness();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
